// File: rtl/controller_scan_v3_if.sv
// CPU-side bus for the controller port block: strobe, address, direction and data.
// The controller drives only cpu_data_out, which the bus fabric ORs into cpu_din.
interface controller_scan_v3_if;
  logic        ph2_falling;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic        cpu_data_in;
  logic [7:0]  cpu_data_out;

  modport master (
    output ph2_falling, cpu_addr, cpu_rnw, cpu_data_in,
    input  cpu_data_out
  );

  modport slave (
    input  ph2_falling, cpu_addr, cpu_rnw, cpu_data_in,
    output cpu_data_out
  );
endinterface

// File: rtl/controller_scan_v3.sv
// Joypad port block: an auto-scan engine fills per-pad shadow registers, and
// CPU reads of $4016/$4017 are served serially from those shadows.
module controller_scan_v3 #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned CLK_HALF  = 150,
  parameter int unsigned LATCH_LEN = 300,
  parameter logic [15:0] BASE_ADDR = 16'h4016
) (
  input  logic                          clk,
  input  logic                          rstn_in,
  controller_scan_v3_if.slave           bus,
  input  logic                          poll_start,
  input  logic [NUM_PORTS-1:0]          pad_data,
  output logic [NUM_PORTS-1:0]          pad_clk,
  output logic                          pad_latch,
  output logic                          scan_busy,
  output logic                          scan_done,
  output logic [NUM_PORTS*NUM_BITS-1:0] buttons
);

  localparam int unsigned NB   = NUM_PORTS * NUM_BITS;
  localparam int unsigned KW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int unsigned PW   = $clog2(NUM_BITS + 1);
  localparam int unsigned TMAX = (LATCH_LEN > CLK_HALF) ? LATCH_LEN : CLK_HALF;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PTR_SAT    = PW'(NUM_BITS);
  localparam logic [KW-1:0] LAST_BIT   = KW'(NUM_BITS - 1);
  localparam logic [TW-1:0] LATCH_LOAD = TW'(LATCH_LEN - 1);
  localparam logic [TW-1:0] CLK_LOAD   = TW'(CLK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SAMPLE, S_CLK_LO, S_CLK_HI, S_COMMIT
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [KW-1:0]   bit_q, bit_d;
  logic [NB-1:0]   cap_q, cap_d;
  logic [NB-1:0]   buttons_q, buttons_d;
  logic            strobe_q, strobe_d;
  logic [PW-1:0]   ptr_q [2];
  logic [PW-1:0]   ptr_d [2];

  logic            sel_lo, sel_hi, wr_lo, rd_lo, rd_hi;
  logic            strobe_fall, trigger;
  logic [3:0]      rd_bit;
  logic [NUM_BITS-1:0] pad_sh, pad_cap;
  logic [PW-1:0]   pad_ptr;

  assign sel_lo      = (bus.cpu_addr == BASE_ADDR);
  assign sel_hi      = (bus.cpu_addr == BASE_ADDR + 16'd1);
  assign wr_lo       = bus.ph2_falling & ~bus.cpu_rnw & sel_lo;
  assign rd_lo       = bus.ph2_falling &  bus.cpu_rnw & sel_lo;
  assign rd_hi       = bus.ph2_falling &  bus.cpu_rnw & sel_hi;
  assign strobe_fall = wr_lo & strobe_q & ~bus.cpu_data_in;
  // A strobe release coinciding with poll_start is a single trigger.
  assign trigger     = poll_start | strobe_fall;

  // Strobe high pins both pointers at 0, which also covers the clear on release.
  always_comb begin
    strobe_d = strobe_q;
    ptr_d    = ptr_q;
    if (wr_lo) strobe_d = bus.cpu_data_in;
    if (strobe_q) begin
      ptr_d[0] = '0;
      ptr_d[1] = '0;
    end else begin
      if (rd_lo && ptr_q[0] != PTR_SAT) ptr_d[0] = ptr_q[0] + 1'b1;
      if (rd_hi && ptr_q[1] != PTR_SAT) ptr_d[1] = ptr_q[1] + 1'b1;
    end
  end

  always_comb begin
    rd_bit  = '0;
    pad_sh  = '0;
    pad_ptr = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      pad_sh  = buttons_q[p*NUM_BITS +: NUM_BITS];
      pad_ptr = ptr_q[p % 2];
      if (pad_ptr >= PTR_SAT) rd_bit[p] = 1'b1;
      else                    rd_bit[p] = pad_sh[pad_ptr[KW-1:0]];
    end
    bus.cpu_data_out = '0;
    if (bus.cpu_rnw && sel_lo)      bus.cpu_data_out[1:0] = {rd_bit[2], rd_bit[0]};
    else if (bus.cpu_rnw && sel_hi) bus.cpu_data_out[1:0] = {rd_bit[3], rd_bit[1]};
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    cap_d     = cap_q;
    buttons_d = buttons_q;
    pad_cap   = '0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_LATCH;
          timer_d = LATCH_LOAD;
          bit_d   = '0;
        end
      end
      S_LATCH: begin
        if (timer_q == '0) state_d = S_SAMPLE;
        else               timer_d = timer_q - 1'b1;
      end
      S_SAMPLE: begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          pad_cap        = cap_q[p*NUM_BITS +: NUM_BITS];
          pad_cap[bit_q] = ~pad_data[p];
          cap_d[p*NUM_BITS +: NUM_BITS] = pad_cap;
        end
        if (bit_q == LAST_BIT) begin
          state_d = S_COMMIT;
        end else begin
          state_d = S_CLK_LO;
          timer_d = CLK_LOAD;
        end
      end
      S_CLK_LO: begin
        if (timer_q == '0) begin
          state_d = S_CLK_HI;
          timer_d = CLK_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_CLK_HI: begin
        if (timer_q == '0) begin
          state_d = S_SAMPLE;
          bit_d   = bit_q + 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_COMMIT: begin
        buttons_d = cap_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      cap_q     <= '0;
      buttons_q <= '0;
      strobe_q  <= 1'b0;
      ptr_q[0]  <= '0;
      ptr_q[1]  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      cap_q     <= cap_d;
      buttons_q <= buttons_d;
      strobe_q  <= strobe_d;
      ptr_q[0]  <= ptr_d[0];
      ptr_q[1]  <= ptr_d[1];
    end
  end

  assign pad_clk   = {NUM_PORTS{state_q != S_CLK_LO}};
  assign pad_latch = (state_q == S_LATCH);
  assign scan_busy = (state_q != S_IDLE);
  assign scan_done = (state_q == S_COMMIT);
  assign buttons   = buttons_q;

endmodule

// File: tb/tb_controller_scan_v3.sv
// Bench for controller_scan_v3: a default 2x8 instance and a fast 4x16 instance,
// each fed by behavioural pads and checked against report/read-order arithmetic.
module tb_controller_scan_v3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #20 clk = ~clk;

  controller_scan_v3_if ifa ();
  controller_scan_v3_if ifb ();

  logic        poll_a, poll_b;
  logic [1:0]  pad_data_a, pad_clk_a;
  logic        pad_latch_a, busy_a, done_a;
  logic [15:0] buttons_a;
  logic [3:0]  pad_data_b, pad_clk_b;
  logic        pad_latch_b, busy_b, done_b;
  logic [63:0] buttons_b;

  controller_scan_v3 #(
    .NUM_PORTS(2), .NUM_BITS(8), .CLK_HALF(150), .LATCH_LEN(300), .BASE_ADDR(16'h4016)
  ) dut_a (
    .clk(clk), .rstn_in(rstn), .bus(ifa), .poll_start(poll_a), .pad_data(pad_data_a),
    .pad_clk(pad_clk_a), .pad_latch(pad_latch_a), .scan_busy(busy_a), .scan_done(done_a),
    .buttons(buttons_a)
  );

  controller_scan_v3 #(
    .NUM_PORTS(4), .NUM_BITS(16), .CLK_HALF(3), .LATCH_LEN(5), .BASE_ADDR(16'h4016)
  ) dut_b (
    .clk(clk), .rstn_in(rstn), .bus(ifb), .poll_start(poll_b), .pad_data(pad_data_b),
    .pad_clk(pad_clk_b), .pad_latch(pad_latch_b), .scan_busy(busy_b), .scan_done(done_b),
    .buttons(buttons_b)
  );

  // Behavioural pads: latch reloads the report, each pad_clk rise shifts to the next button.
  logic [7:0]  rep_a [2];
  logic [15:0] rep_b [4];
  int idx_a = 0, idx_b = 0;
  logic prev_a = 1'b1, prev_b = 1'b1;

  always @(posedge clk) begin
    if (pad_latch_a)                 idx_a <= 0;
    else if (pad_clk_a[0] && !prev_a) idx_a <= idx_a + 1;
    prev_a <= pad_clk_a[0];
    if (pad_latch_b)                 idx_b <= 0;
    else if (pad_clk_b[0] && !prev_b) idx_b <= idx_b + 1;
    prev_b <= pad_clk_b[0];
  end

  always_comb begin
    for (int i = 0; i < 2; i++) pad_data_a[i] = (idx_a < 8)  ? ~rep_a[i][idx_a] : 1'b0;
    for (int i = 0; i < 4; i++) pad_data_b[i] = (idx_b < 16) ? ~rep_b[i][idx_b] : 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // k-th read after a pointer clear returns button k, then 1 once past the report.
  function automatic logic [7:0] exp_read(input logic [15:0] lo, input logic [15:0] hi,
                                          input bit hi_present, input int k, input int nbits);
    logic b0, b1;
    b0 = (k >= nbits) ? 1'b1 : 1'((lo >> k) & 16'd1);
    b1 = !hi_present ? 1'b0 : (k >= nbits) ? 1'b1 : 1'((hi >> k) & 16'd1);
    return {6'b0, b1, b0};
  endfunction

  task automatic cpu_op(input bit b, input logic [15:0] addr, input bit rnw, input bit din,
                        output logic [7:0] dout);
    @(negedge clk);
    if (!b) begin
      ifa.cpu_addr = addr; ifa.cpu_rnw = rnw; ifa.cpu_data_in = din; ifa.ph2_falling = 1'b1;
    end else begin
      ifb.cpu_addr = addr; ifb.cpu_rnw = rnw; ifb.cpu_data_in = din; ifb.ph2_falling = 1'b1;
    end
    #1 dout = b ? ifb.cpu_data_out : ifa.cpu_data_out;
    @(negedge clk);
    ifa.ph2_falling = 1'b0; ifa.cpu_addr = 16'h0000; ifa.cpu_rnw = 1'b1;
    ifb.ph2_falling = 1'b0; ifb.cpu_addr = 16'h0000; ifb.cpu_rnw = 1'b1;
  endtask

  task automatic wait_idle(input bit b, output int cyc);
    cyc = -1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (!(b ? busy_b : busy_a)) begin
        cyc = c;
        break;
      end
    end
  endtask

  // One scan on dut_a; optionally re-pulses poll_start mid-scan at cycle repoll_at.
  task automatic run_scan_a(input int repoll_at, output int done_cyc, output int latch_cnt,
                            output int pulses, output int done_cnt, output logic busy_after);
    logic prev;
    @(negedge clk); poll_a = 1'b1;
    @(negedge clk); poll_a = 1'b0;
    done_cyc = -1; latch_cnt = 0; pulses = 0; done_cnt = 0; busy_after = 1'b1; prev = 1'b1;
    for (int c = 1; c <= 2600; c++) begin
      if (pad_latch_a) latch_cnt++;
      if (!pad_clk_a[0] && prev) pulses++;
      prev = pad_clk_a[0];
      if (done_a) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc > 0 && c == done_cyc + 1) busy_after = busy_a;
      poll_a = (c == repoll_at);
      @(negedge clk);
    end
    poll_a = 1'b0;
  endtask

  localparam int SCAN_A = 300 + 1 + (8 - 1) * (2 * 150 + 1) + 1;
  localparam int SCAN_B = 5 + 1 + (16 - 1) * (2 * 3 + 1) + 1;

  initial begin
    int done_cyc, latch_cnt, pulses, done_cnt, cyc;
    logic busy_after, found;
    logic [7:0] d;

    ifa.ph2_falling = 1'b0; ifa.cpu_addr = '0; ifa.cpu_rnw = 1'b1; ifa.cpu_data_in = 1'b0;
    ifb.ph2_falling = 1'b0; ifb.cpu_addr = '0; ifb.cpu_rnw = 1'b1; ifb.cpu_data_in = 1'b0;
    poll_a = 1'b0; poll_b = 1'b0;
    rep_a[0] = 8'h81; rep_a[1] = 8'($urandom);
    for (int i = 0; i < 4; i++) rep_b[i] = 16'($urandom);
    rep_b[3] = 16'h0F00;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pad_clk_a", pad_clk_a, 2'b11);
    check("rst_latch_a", pad_latch_a, 1'b0);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_buttons_a", buttons_a, 16'h0);
    check("rst_pad_clk_b", pad_clk_b, 4'hF);
    check("rst_buttons_b", buttons_b, 64'h0);
    rstn = 1'b1;
    cpu_op(0, 16'h4016, 1'b1, 1'b0, d);
    check("rst_read_4016", d, 8'h00);

    // Full default-timing scan with a dropped mid-scan poll_start.
    run_scan_a(1000, done_cyc, latch_cnt, pulses, done_cnt, busy_after);
    check("scan_a_done_cycle", done_cyc, SCAN_A);
    check("scan_a_latch_len", latch_cnt, 300);
    check("scan_a_clk_pulses", pulses, 7);
    check("scan_a_done_count", done_cnt, 1);
    check("scan_a_busy_after", busy_after, 1'b0);
    check("scan_a_buttons", buttons_a, {rep_a[1], rep_a[0]});

    // Strobe release, then serial reads of both addresses.
    cpu_op(0, 16'h4016, 1'b0, 1'b1, d);
    cpu_op(0, 16'h4016, 1'b0, 1'b0, d);
    for (int k = 0; k < 9; k++) begin
      cpu_op(0, 16'h4016, 1'b1, 1'b0, d);
      check($sformatf("a_rd4016_%0d", k), d, exp_read(16'(rep_a[0]), 16'h0, 1'b0, k, 8));
    end
    for (int k = 0; k < 9; k++) begin
      cpu_op(0, 16'h4017, 1'b1, 1'b0, d);
      check($sformatf("a_rd4017_%0d", k), d, exp_read(16'(rep_a[1]), 16'h0, 1'b0, k, 8));
    end
    cpu_op(0, 16'h4018, 1'b1, 1'b0, d);
    check("a_rd4018", d, 8'h00);
    cpu_op(0, 16'h4015, 1'b1, 1'b0, d);
    check("a_rd4015", d, 8'h00);
    wait_idle(0, cyc);
    check("a_idle_after_strobe_scan", cyc >= 0, 1'b1);

    // $4017 writes must not act as a strobe.
    cpu_op(0, 16'h4017, 1'b0, 1'b1, d);
    cpu_op(0, 16'h4017, 1'b0, 1'b0, d);
    #1 check("a_4017_write_no_scan", busy_a, 1'b0);

    // Strobe held high: reads repeat button 0.
    cpu_op(0, 16'h4016, 1'b0, 1'b1, d);
    for (int k = 0; k < 3; k++) begin
      cpu_op(0, 16'h4016, 1'b1, 1'b0, d);
      check($sformatf("a_strobe_rd_%0d", k), d, exp_read(16'(rep_a[0]), 16'h0, 1'b0, 0, 8));
    end
    cpu_op(0, 16'h4016, 1'b0, 1'b0, d);
    for (int k = 0; k < 2; k++) begin
      cpu_op(0, 16'h4016, 1'b1, 1'b0, d);
      check($sformatf("a_post_strobe_rd_%0d", k), d, exp_read(16'(rep_a[0]), 16'h0, 1'b0, k, 8));
    end
    wait_idle(0, cyc);
    check("a_idle_after_strobe2", cyc >= 0, 1'b1);

    // Four 16-bit pads on the fast instance.
    @(negedge clk); poll_b = 1'b1;
    @(negedge clk); poll_b = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 500; c++) begin
      if (done_b) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    check("scan_b_done_cycle", done_cyc, SCAN_B);
    @(negedge clk);
    check("scan_b_buttons", buttons_b, {rep_b[3], rep_b[2], rep_b[1], rep_b[0]});
    cpu_op(1, 16'h4016, 1'b0, 1'b1, d);
    cpu_op(1, 16'h4016, 1'b0, 1'b0, d);
    for (int k = 0; k < 17; k++) begin
      cpu_op(1, 16'h4017, 1'b1, 1'b0, d);
      check($sformatf("b_rd4017_%0d", k), d, exp_read(rep_b[1], rep_b[3], 1'b1, k, 16));
    end
    for (int k = 0; k < 17; k++) begin
      cpu_op(1, 16'h4016, 1'b1, 1'b0, d);
      check($sformatf("b_rd4016_%0d", k), d, exp_read(rep_b[0], rep_b[2], 1'b1, k, 16));
    end
    wait_idle(1, cyc);
    check("b_idle", cyc >= 0, 1'b1);

    // Asynchronous reset in the middle of a pad clock low phase.
    rep_a[0] = 8'($urandom); rep_a[1] = 8'($urandom);
    @(negedge clk); poll_a = 1'b1;
    @(negedge clk); poll_a = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!pad_clk_a[0]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("a_reached_clk_lo", found, 1'b1);
    repeat (20) @(posedge clk);
    #7 rstn = 1'b0;
    #1;
    check("mid_rst_pad_clk", pad_clk_a, 2'b11);
    check("mid_rst_latch", pad_latch_a, 1'b0);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_done", done_a, 1'b0);
    check("mid_rst_buttons", buttons_a, 16'h0);
    @(negedge clk);
    rstn = 1'b1;
    run_scan_a(-1, done_cyc, latch_cnt, pulses, done_cnt, busy_after);
    check("rescan_done_cycle", done_cyc, SCAN_A);
    check("rescan_clk_pulses", pulses, 7);
    check("rescan_buttons", buttons_a, {rep_a[1], rep_a[0]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
